// File: rtl/fhe_alu_pkg.sv
// Shared FHE ALU constants: NTT/INTT source count, root-power bank count and
// the lane/address geometry used by the root address routing network.
package fhe_alu_pkg;

    localparam int POLY_N         = 4096;
    localparam int NTT_E          = 8;
    localparam int LOG_E          = $clog2(NTT_E);
    localparam int NTT_INTT_NUM   = 4;
    localparam int ROOT_POWER_NUM = 4;
    localparam int LANES          = LOG_E;
    localparam int ADDR_W         = $clog2(POLY_N / (NTT_E / 2));
    localparam int ROUTE_SEL_W    = $clog2(NTT_INTT_NUM);

    typedef logic [ROUTE_SEL_W-1:0] route_sel_t;

    // Power-on static map: destination d listens to source d mod num_src.
    function automatic int identity_src(input int dst, input int num_src);
        return dst % num_src;
    endfunction

endpackage

// File: rtl/route_mux_stage.sv
// One binary mux-tree level: picks even/odd of each input pair by the LSB of
// the travelling select, then registers data, valid and the remaining select bits.
module route_mux_stage #(
    parameter int N_OUT = 1,
    parameter int DW    = 2,
    parameter int SW    = 1
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            i_en,
    input  logic [2*N_OUT-1:0][DW-1:0]      i_data,
    input  logic [SW-1:0]                   i_sel,
    output logic [N_OUT-1:0][DW-1:0]        o_data,
    output logic [((SW > 1) ? SW-1 : 1)-1:0] o_sel,
    output logic                            o_any_vld
);

    logic [N_OUT-1:0][DW-1:0] w_pick;
    logic [N_OUT-1:0][DW-1:0] r_data;

    always_comb begin
        for (int i = 0; i < N_OUT; i++) begin
            w_pick[i] = i_sel[0] ? i_data[2*i+1] : i_data[2*i];
        end
    end

    // Valid bit is the MSB; the address only moves with a valid bundle so the
    // bank-side address holds its last value while idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data <= '0;
        end else if (i_en) begin
            for (int i = 0; i < N_OUT; i++) begin
                r_data[i][DW-1] <= w_pick[i][DW-1];
                if (w_pick[i][DW-1]) begin
                    r_data[i][DW-2:0] <= w_pick[i][DW-2:0];
                end
            end
        end
    end

    always_comb begin
        o_any_vld = 1'b0;
        for (int i = 0; i < N_OUT; i++) begin
            o_any_vld = o_any_vld | r_data[i][DW-1];
        end
    end

    generate
        if (SW > 1) begin : g_fwd
            logic [SW-2:0] r_sel;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_sel <= '0;
                end else if (i_en) begin
                    r_sel <= i_sel[SW-1:1];
                end
            end
            assign o_sel = r_sel;
        end else begin : g_end
            assign o_sel = 1'b0;
        end
    endgenerate

    assign o_data = r_data;

endmodule

// File: rtl/root_addr_route_net.sv
// Routes NTT/INTT address bundles to root-power banks through one pipelined
// binary mux tree per bank; select is captured at entry and travels with data.
module root_addr_route_net #(
    parameter int  NUM_SRC = fhe_alu_pkg::NTT_INTT_NUM,
    parameter int  NUM_DST = fhe_alu_pkg::ROOT_POWER_NUM,
    parameter int  LANES   = fhe_alu_pkg::LANES,
    parameter int  ADDR_W  = fhe_alu_pkg::ADDR_W,
    localparam int STAGES  = $clog2(NUM_SRC)
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic [NUM_SRC-1:0][LANES-1:0][ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0]                       src_valid,
    input  logic [NUM_DST-1:0][STAGES-1:0]           dyn_sel,
    input  logic [NUM_DST-1:0][STAGES-1:0]           cfg_sel,
    input  logic                                     cfg_load,
    input  logic                                     mode,
    input  logic                                     en,
    output logic [NUM_DST-1:0][LANES-1:0][ADDR_W-1:0] dst_addr,
    output logic [NUM_DST-1:0]                       dst_valid,
    output logic                                     cfg_busy,
    output logic                                     cfg_rej
);
    import fhe_alu_pkg::*;

    localparam int DW = 1 + LANES * ADDR_W;

    logic [NUM_DST-1:0][STAGES-1:0] r_static_sel;
    logic [NUM_DST-1:0][STAGES-1:0] w_sel_now;
    logic [NUM_SRC-1:0][DW-1:0]     w_src;
    logic [NUM_DST-1:0]             w_dst_busy;
    logic                           r_cfg_rej;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            w_src[i] = {src_valid[i], src_addr[i]};
        end
    end

    assign w_sel_now = mode ? dyn_sel : r_static_sel;

    // A load is only accepted with the pipe empty so no in-flight bundle can
    // see a half-updated map.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int d = 0; d < NUM_DST; d++) begin
                r_static_sel[d] <= STAGES'(identity_src(d, NUM_SRC));
            end
            r_cfg_rej <= 1'b0;
        end else begin
            r_cfg_rej <= cfg_load && cfg_busy;
            if (cfg_load && !cfg_busy) begin
                r_static_sel <= cfg_sel;
            end
        end
    end

    generate
        for (genvar d = 0; d < NUM_DST; d++) begin : g_dst
            logic [STAGES-1:0] w_lvl_busy;

            for (genvar s = 0; s < STAGES; s++) begin : g_lvl
                localparam int N_OUT = NUM_SRC >> (s + 1);
                localparam int SW    = STAGES - s;
                localparam int OSW   = (SW > 1) ? SW - 1 : 1;

                logic [2*N_OUT-1:0][DW-1:0] w_in;
                logic [SW-1:0]              w_sel_in;
                logic [N_OUT-1:0][DW-1:0]   w_out;
                logic [OSW-1:0]             w_sel_out;

                if (s == 0) begin : g_head
                    assign w_in     = w_src;
                    assign w_sel_in = w_sel_now[d];
                end else begin : g_tail
                    assign w_in     = g_lvl[s-1].w_out;
                    assign w_sel_in = g_lvl[s-1].w_sel_out;
                end

                // The last level has no select bits left to forward.
                if (s == STAGES - 1) begin : g_last
                    logic w_unused_sel;
                    assign w_unused_sel = |w_sel_out;
                end

                route_mux_stage #(
                    .N_OUT (N_OUT),
                    .DW    (DW),
                    .SW    (SW)
                ) u_stage (
                    .clk       (clk),
                    .rstn      (rstn),
                    .i_en      (en),
                    .i_data    (w_in),
                    .i_sel     (w_sel_in),
                    .o_data    (w_out),
                    .o_sel     (w_sel_out),
                    .o_any_vld (w_lvl_busy[s])
                );
            end

            assign dst_valid[d]  = g_lvl[STAGES-1].w_out[0][DW-1];
            assign dst_addr[d]   = g_lvl[STAGES-1].w_out[0][DW-2:0];
            assign w_dst_busy[d] = |w_lvl_busy;
        end
    endgenerate

    assign cfg_busy = |w_dst_busy;
    assign cfg_rej  = r_cfg_rej;

endmodule

// File: tb/tb_root_addr_route_net.sv
// Directed bench for root_addr_route_net: 4-source instance for static/dynamic
// routing, config reject, stall and reset; 8-source instance for streaming selects.
module tb_root_addr_route_net;
    import fhe_alu_pkg::*;

    localparam int BW = LANES * ADDR_W;
    localparam int NB = 6;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [3:0][LANES-1:0][ADDR_W-1:0] a_src_addr;
    logic [3:0]                        a_src_valid;
    logic [3:0][1:0]                   a_dyn_sel;
    logic [3:0][1:0]                   a_cfg_sel;
    logic                              a_cfg_load, a_mode, a_en;
    logic [3:0][LANES-1:0][ADDR_W-1:0] a_dst_addr;
    logic [3:0]                        a_dst_valid;
    logic                              a_busy, a_rej;

    logic [7:0][LANES-1:0][ADDR_W-1:0] b_src_addr;
    logic [7:0]                        b_src_valid;
    logic [3:0][2:0]                   b_dyn_sel;
    logic [3:0][2:0]                   b_cfg_sel;
    logic                              b_cfg_load, b_mode, b_en;
    logic [3:0][LANES-1:0][ADDR_W-1:0] b_dst_addr;
    logic [3:0]                        b_dst_valid;
    logic                              b_busy, b_rej;

    root_addr_route_net u_dut4 (
        .clk(clk), .rstn(rstn), .src_addr(a_src_addr), .src_valid(a_src_valid),
        .dyn_sel(a_dyn_sel), .cfg_sel(a_cfg_sel), .cfg_load(a_cfg_load),
        .mode(a_mode), .en(a_en), .dst_addr(a_dst_addr), .dst_valid(a_dst_valid),
        .cfg_busy(a_busy), .cfg_rej(a_rej)
    );

    root_addr_route_net #(.NUM_SRC(8), .NUM_DST(4)) u_dut8 (
        .clk(clk), .rstn(rstn), .src_addr(b_src_addr), .src_valid(b_src_valid),
        .dyn_sel(b_dyn_sel), .cfg_sel(b_cfg_sel), .cfg_load(b_cfg_load),
        .mode(b_mode), .en(b_en), .dst_addr(b_dst_addr), .dst_valid(b_dst_valid),
        .cfg_busy(b_busy), .cfg_rej(b_rej)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] mk(input int src, input int base);
        logic [BW-1:0] r;
        for (int l = 0; l < LANES; l++) begin
            r[l*ADDR_W +: ADDR_W] = ADDR_W'(base + src) | ADDR_W'(l << 8);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load4(input int base, input logic [3:0] vld);
        for (int i = 0; i < 4; i++) a_src_addr[i] = mk(i, base);
        a_src_valid = vld;
    endtask

    task automatic chk_out4(input string tag, input logic [3:0] ev,
                            input logic [BW-1:0] e0, input logic [BW-1:0] e1,
                            input logic [BW-1:0] e2, input logic [BW-1:0] e3);
        chk({tag, "_vld"}, 64'(a_dst_valid), 64'(ev));
        chk({tag, "_a0"}, 64'(a_dst_addr[0]), 64'(e0));
        chk({tag, "_a1"}, 64'(a_dst_addr[1]), 64'(e1));
        chk({tag, "_a2"}, 64'(a_dst_addr[2]), 64'(e2));
        chk({tag, "_a3"}, 64'(a_dst_addr[3]), 64'(e3));
    endtask

    int            sel_tab [NB][4] = '{'{0, 1, 2, 3}, '{7, 7, 7, 7}, '{5, 2, 6, 1},
                                       '{3, 4, 0, 7}, '{6, 6, 1, 1}, '{2, 5, 4, 0}};
    logic [7:0]    vld_tab [NB]    = '{8'hFF, 8'hFF, 8'hA5, 8'h3C, 8'hFF, 8'h0F};
    logic [BW-1:0] last_b  [4];

    initial begin
        rstn = 1'b0;
        a_src_addr = '0; a_src_valid = '0; a_dyn_sel = '0; a_cfg_sel = '0;
        a_cfg_load = 1'b0; a_mode = 1'b0; a_en = 1'b1;
        b_src_addr = '0; b_src_valid = '0; b_dyn_sel = '0; b_cfg_sel = '0;
        b_cfg_load = 1'b0; b_mode = 1'b0; b_en = 1'b1;
        repeat (3) step();

        // Reset state
        chk("rst_vld4", 64'(a_dst_valid), 64'd0);
        chk("rst_busy4", 64'(a_busy), 64'd0);
        chk("rst_rej4", 64'(a_rej), 64'd0);
        for (int d = 0; d < 4; d++) chk($sformatf("rst_addr4_%0d", d), 64'(a_dst_addr[d]), 64'd0);
        chk("rst_vld8", 64'(b_dst_valid), 64'd0);
        #3 rstn = 1'b1;
        step();

        // Static identity, two-cycle latency
        load4('h10, 4'hF);
        step();
        chk("t35_lat", 64'(a_dst_valid), 64'd0);
        chk("t35_busy", 64'(a_busy), 64'd1);
        load4('h3F, 4'h0);
        step();
        chk_out4("t35", 4'hF, mk(0, 'h10), mk(1, 'h10), mk(2, 'h10), mk(3, 'h10));
        step();
        chk_out4("t35_hold", 4'h0, mk(0, 'h10), mk(1, 'h10), mk(2, 'h10), mk(3, 'h10));
        chk("t35_idle", 64'(a_busy), 64'd0);

        // Dynamic mode with multicast; selects change right after entry
        a_mode = 1'b1;
        a_dyn_sel = {2'd3, 2'd3, 2'd0, 2'd1};
        load4('h20, 4'b1011);
        step();
        a_dyn_sel = {2'd2, 2'd1, 2'd0, 2'd2};
        load4('h28, 4'b0011);
        step();
        chk_out4("t36a", 4'hF, mk(1, 'h20), mk(0, 'h20), mk(3, 'h20), mk(3, 'h20));
        a_dyn_sel = {2'd3, 2'd3, 2'd3, 2'd3};
        load4('h30, 4'h0);
        step();
        chk_out4("t36b", 4'b0110, mk(1, 'h20), mk(0, 'h28), mk(1, 'h28), mk(3, 'h20));
        step();
        chk("t36_drain", 64'(a_dst_valid), 64'd0);

        // Config load rejected while busy, accepted when idle
        a_mode = 1'b0;
        load4('h40, 4'hF);
        step();
        chk("t37_busy", 64'(a_busy), 64'd1);
        a_cfg_sel = {2'd0, 2'd1, 2'd2, 2'd3};
        a_cfg_load = 1'b1;
        load4('h48, 4'h0);
        step();
        a_cfg_load = 1'b0;
        chk("t37_rej", 64'(a_rej), 64'd1);
        chk_out4("t37a", 4'hF, mk(0, 'h40), mk(1, 'h40), mk(2, 'h40), mk(3, 'h40));
        step();
        chk("t37_rej_pulse", 64'(a_rej), 64'd0);
        chk("t37_idle", 64'(a_busy), 64'd0);
        load4('h50, 4'hF);
        step();
        load4('h58, 4'h0);
        step();
        chk_out4("t37_kept", 4'hF, mk(0, 'h50), mk(1, 'h50), mk(2, 'h50), mk(3, 'h50));
        step();
        chk("t37_idle2", 64'(a_busy), 64'd0);
        a_cfg_load = 1'b1;
        step();
        a_cfg_load = 1'b0;
        chk("t37_acc_rej", 64'(a_rej), 64'd0);
        load4('h60, 4'hF);
        step();
        load4('h68, 4'h0);
        step();
        chk_out4("t37_new", 4'hF, mk(3, 'h60), mk(2, 'h60), mk(1, 'h60), mk(0, 'h60));
        step();

        // Three-cycle stall with a bundle on the outputs and one behind it
        a_mode = 1'b1;
        a_dyn_sel = {2'd3, 2'd2, 2'd1, 2'd0};
        load4('h70, 4'hF);
        step();
        load4('h78, 4'hF);
        step();
        chk_out4("t38_a", 4'hF, mk(0, 'h70), mk(1, 'h70), mk(2, 'h70), mk(3, 'h70));
        a_en = 1'b0;
        load4('h08, 4'hF);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out4($sformatf("t38_frz%0d", k), 4'hF, mk(0, 'h70), mk(1, 'h70), mk(2, 'h70), mk(3, 'h70));
        end
        a_en = 1'b1;
        load4('h18, 4'h0);
        step();
        chk_out4("t38_b", 4'hF, mk(0, 'h78), mk(1, 'h78), mk(2, 'h78), mk(3, 'h78));
        step();
        chk_out4("t38_end", 4'h0, mk(0, 'h78), mk(1, 'h78), mk(2, 'h78), mk(3, 'h78));

        // Reset with two bundles in flight; static map returns to identity
        a_mode = 1'b0;
        load4('h80, 4'hF);
        step();
        load4('h88, 4'hF);
        step();
        load4('h98, 4'h0);
        #2 rstn = 1'b0;
        #1;
        chk("t39_vld", 64'(a_dst_valid), 64'd0);
        chk("t39_busy", 64'(a_busy), 64'd0);
        chk("t39_addr0", 64'(a_dst_addr[0]), 64'd0);
        #1 rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("t39_quiet%0d", k), 64'(a_dst_valid), 64'd0);
        end
        load4('h90, 4'hF);
        step();
        load4('h98, 4'h0);
        step();
        chk_out4("t39_ident", 4'hF, mk(0, 'h90), mk(1, 'h90), mk(2, 'h90), mk(3, 'h90));
        step();

        // Eight sources: select changes every cycle while streaming
        b_mode = 1'b1;
        for (int d = 0; d < 4; d++) last_b[d] = '0;
        for (int c = 0; c < NB + 2; c++) begin
            if (c < NB) begin
                for (int i = 0; i < 8; i++) b_src_addr[i] = mk(i, 'h20 + 8 * c);
                b_src_valid = vld_tab[c];
                for (int d = 0; d < 4; d++) b_dyn_sel[d] = 3'(sel_tab[c][d]);
            end else begin
                for (int i = 0; i < 8; i++) b_src_addr[i] = mk(i, $urandom_range(0, 'hFF));
                b_src_valid = '0;
                for (int d = 0; d < 4; d++) b_dyn_sel[d] = 3'($urandom_range(0, 7));
            end
            step();
            if (c >= 2) begin
                for (int d = 0; d < 4; d++) begin
                    int  s;
                    logic ev;
                    s  = sel_tab[c-2][d];
                    ev = vld_tab[c-2][s];
                    if (ev) last_b[d] = mk(s, 'h20 + 8 * (c - 2));
                    chk($sformatf("t40_vld_b%0d_d%0d", c - 2, d), 64'(b_dst_valid[d]), 64'(ev));
                    chk($sformatf("t40_addr_b%0d_d%0d", c - 2, d), 64'(b_dst_addr[d]), 64'(last_b[d]));
                end
            end
        end
        step();
        chk("t40_drain", 64'(b_dst_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/root_addr_route_net.md
ROOT_ADDR_ROUTE_NET -- requirements
Module: root_addr_route_net

Interface
REQ-001 Parameter NUM_SRC, default 4, SHALL set the number of NTT/INTT address sources; power of two, >=2.
REQ-002 Parameter NUM_DST, default 4, SHALL set the number of root-power bank destinations; >=1.
REQ-003 Parameter LANES, default logE, SHALL set the number of address lanes per port.
REQ-004 Parameter ADDR_W, default $clog2(N/(E/2)), SHALL set the per-lane address width.
REQ-005 Derived constant STAGES = $clog2(NUM_SRC) SHALL set the mux-tree depth and latency.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rstn  input  1  asynchronous, active-low reset.
REQ-008 src_addr  input  NUM_SRC x LANES x ADDR_W  per-source address bundle.
REQ-009 src_valid  input  NUM_SRC  per-source bundle valid.
REQ-010 dyn_sel  input  NUM_DST x STAGES  per-destination source index, dynamic mode.
REQ-011 cfg_sel  input  NUM_DST x STAGES  per-destination source index, static-mode load value.
REQ-012 cfg_load  input  1  static-config load strobe.
REQ-013 mode  input  1  0 = static (latched select), 1 = dynamic (per-cycle select).
REQ-014 en  input  1  pipeline advance enable; 0 stalls every stage.
REQ-015 dst_addr  output  NUM_DST x LANES x ADDR_W  routed address per bank.
REQ-016 dst_valid  output  NUM_DST  routed valid per bank.
REQ-017 cfg_busy  output  1  high while any stage holds a valid bundle.
REQ-018 cfg_rej  output  1  one-cycle pulse when a cfg_load is rejected.

Function
REQ-019 Each destination SHALL own an independent binary mux tree of STAGES levels; level s SHALL pick odd/even input pair by bit s of that destination's select, LSB first.
REQ-020 A pipeline register (address, valid, remaining select bits) SHALL follow every level; latency src->dst SHALL be exactly STAGES cycles with en held high.
REQ-021 The select used by a bundle SHALL be captured in the cycle the bundle enters level 0 and SHALL travel with it; later select changes SHALL NOT affect in-flight data.
REQ-022 Multicast (several destinations choosing one source) SHALL be legal; no conflict check.
REQ-023 dst_valid SHALL equal the selected source's src_valid delayed STAGES advancing cycles; dst_addr SHALL hold its last value when dst_valid is 0.
REQ-024 With en=0 all stage registers SHALL hold; inputs presented during a stall SHALL be ignored.
REQ-025 Static mode: cfg_load with cfg_busy=0 SHALL latch cfg_sel into the static-select register at the next edge, effective for bundles entering the following cycle.
REQ-026 cfg_load with cfg_busy=1 SHALL leave the static-select register unchanged and pulse cfg_rej for one cycle.
REQ-027 cfg_busy SHALL be the OR of all stage valid bits; input-stage src_valid SHALL NOT count.
REQ-028 Switching mode SHALL take effect for the next bundle entering level 0; in-flight bundles keep their captured select.
REQ-029 Select values are always in range (power-of-two NUM_SRC); no out-of-range handling.

Reset
REQ-030 On rstn low, all stage valid bits, dst_valid, cfg_busy and cfg_rej SHALL clear to 0 immediately.
REQ-031 On rstn low, dst_addr and stage addresses SHALL clear to 0 and the static-select register SHALL reset to identity (dst d selects source d mod NUM_SRC).
REQ-032 Reset mid-transfer SHALL discard in-flight bundles; no output valid SHALL appear from pre-reset inputs.

Structure
REQ-033 NUM_SRC/NUM_DST defaults (NTT_INTT_NUM, ROOT_POWER_NUM), LANES, ADDR_W and a route-select typedef SHALL live in FHE_ALU_PKG.
REQ-034 One sub-module, route_mux_stage (one 2:1 level plus register, parametrised width), SHALL be instantiated per level per destination.

Verification
REQ-035 Static identity after reset, src_valid=1111, addresses 0x10..0x13 -> dst_addr = 0x10..0x13 exactly 2 cycles later (NUM_SRC=4).
REQ-036 Dynamic mode, dyn_sel={3,3,0,1} -> dst0..3 receive src1,src0,src3,src3 after 2 cycles; multicast of src3 correct on both banks.
REQ-037 Bundle in flight, cfg_load asserted -> cfg_rej pulses one cycle, select unchanged; cfg_load at cfg_busy=0 -> new map used by next bundle.
REQ-038 en low for 3 cycles mid-stream -> outputs frozen, no bundle lost or duplicated, total latency 2+3 cycles.
REQ-039 rstn asserted with 2 bundles in flight -> dst_valid=0 same cycle and stays 0 until new inputs propagate.
REQ-040 Change dyn_sel every cycle with streaming data, NUM_SRC=8 -> each output matches select captured at entry, latency 3.
